lcd_text_writer: RTL and testbench
==================================

// Module: lcd_text_writer
// PURPOSE
//  Consumer end of the 32-cell character interface (index -> out byte) used by the watch mode blocks.
//  Walks index 0..31, fetches each ASCII byte and writes it to a 16x2 HD44780-type LCD in 8-bit mode.
//  Runs power-up init once, then refreshes both lines continuously.
//  Sits between the mode mux (char source) and the LCD pins.
// PARAMETERS
//  PWR_CYC    750000  cycles held idle after reset before the first command (15 ms @50 MHz)
//  E_CYC      25      width of the lcd_e high pulse, in cycles
//  CMD_CYC    2500    wait after every normal command/data write (50 us)
//  CLR_CYC    100000  wait after the clear-display command 0x01 (2 ms)
//  REFR_CYC   500000  idle gap between the end of one frame and the start of the next
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-high reset
//  index       out  5  cell being requested from the char source: 0-15 line 1, 16-31 line 2
//  char_in     in   8  ASCII byte from the char source; the source registers it, so it is valid 1 cycle after index changes
//  lcd_e       out  1  LCD enable strobe
//  lcd_rs      out  1  0 = command, 1 = data
//  lcd_rw      out  1  fixed 0 (write only)
//  lcd_data    out  8  LCD data bus
//  frame_done  out  1  one-cycle pulse after cell 31 has been written
//  init_done   out  1  high once the init sequence has completed; cleared only by rst
// BEHAVIOUR
//  - Reset values: index=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, frame_done=0, init_done=0.
//    All outputs are registered. Reset mid-write drops lcd_e the next cycle and restarts from PWR_WAIT.
//  - States:
//    - PWR_WAIT: count PWR_CYC, then go to INIT.
//    - INIT: write 0x38, 0x0C, 0x06, 0x01 in that order. Wait CMD_CYC after each, except CLR_CYC after 0x01.
//      Then set init_done and go to ADDR1.
//    - ADDR1: command 0x80. Then CHAR with index=0.
//    - CHAR: FETCH (2 cycles: present index, then latch char_in into lcd_data), then a data write with rs=1.
//      After index 15 go to ADDR2. After index 31 go to REFRESH.
//    - ADDR2: command 0xC0. Then CHAR with index=16.
//    - REFRESH: pulse frame_done, idle REFR_CYC, then index=0 and go to ADDR1.
//  - Write cycle, shared by commands and data:
//    - Cycle 0: set up lcd_rs and lcd_data.
//    - Cycles 1..E_CYC: lcd_e=1.
//    - Then lcd_e=0 and lcd_data/lcd_rs held for at least 1 cycle.
//    - Then the post-write wait counter runs.
//    - lcd_data and lcd_rs never change while lcd_e=1.
//  - Cell index sequencing:
//    - index is a 5-bit counter and is only advanced after a data write's wait has finished.
//    - 31 wraps to 0 through REFRESH, never directly.
//    - index is stable from FETCH through the end of the write.
//  - A char_in change during a write has no effect; the byte latched at FETCH is the one written.
//  - Counters: one shared wait counter, wide enough for max(PWR_CYC, CLR_CYC, REFR_CYC). It counts down to 0; the terminal count of 0 ends the wait.
//  - lcd_rw is tied to 0. No busy-flag read.
// STRUCTURE
//  - Shared package lcd_pkg:
//    - state encodings
//    - command constants LCD_FUNC=8'h38, LCD_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLR=8'h01, LCD_L1=8'h80, LCD_L2=8'hC0
//    - the init table
//  - Sub-module lcd_write_strobe: takes start/rs/byte and produces lcd_e/rs/data plus the post-wait done pulse.
//    The top FSM only sequences addresses, commands and indexes.
// TESTING (use PWR_CYC=20, E_CYC=2, CMD_CYC=4, CLR_CYC=10, REFR_CYC=30)
//  1. Release rst; monitor the bus.
//     -> no lcd_e edge for 20 cycles.
//     -> then four E pulses with rs=0, data 38, 0C, 06, 01.
//     -> gap after 01 is >= 10 cycles.
//     -> init_done rises after that gap.
//  2. Char source model (1-cycle registered ROM) returning "SET  2000/00/00 " / "TIME 00:00:00   ".
//     -> bus shows 0x80, then 16 data writes 53 45 54 20 20 32 ..., then 0xC0, then 54 49 4D 45 ....
//     -> frame_done pulses once after byte 31.
//  3. Let two frames run.
//     -> index goes 31 -> 0 only after REFRESH (30 idle cycles).
//     -> the second frame starts with 0x80 and no re-init.
//  4. Change char_in every cycle during a write.
//     -> lcd_data constant while lcd_e=1.
//     -> written byte equals the ROM[index] value latched at FETCH.
//  5. Assert rst for 1 cycle while lcd_e=1 during cell 7.
//     -> next cycle lcd_e=0, index=0, init_done=0.
//     -> full init repeats as in scenario 1.
//  6. Protocol checker across all scenarios: rs/data are stable across every E high window, E high width = 2, lcd_rw is always 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the 16x2 character LCD writer.
//  - lcd_state_e : top-level sequencer states
//  - wr_phase_e  : phases of one bus write / timed wait
//  - HD44780 command bytes and the power-up init table
//  - max2        : helper for sizing the shared wait counter
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_PWR_GO,
    ST_PWR_WAIT,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_ADDR1_GO,
    ST_ADDR1_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_CHAR_WAIT,
    ST_ADDR2_GO,
    ST_ADDR2_WAIT,
    ST_REFR_GO,
    ST_REFR_WAIT
  } lcd_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHIGH,
    PH_HOLD,
    PH_WAIT
  } wr_phase_e;

  localparam logic [7:0] LCD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_ON    = 8'h0C;
  localparam logic [7:0] LCD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CLR   = 8'h01;
  localparam logic [7:0] LCD_L1    = 8'h80;
  localparam logic [7:0] LCD_L2    = 8'hC0;

  // Number of commands in the init table; the last one is the clear.
  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    init_cmd = LCD_FUNC;
      2'd1:    init_cmd = LCD_ON;
      2'd2:    init_cmd = LCD_ENTRY;
      default: init_cmd = LCD_CLR;
    endcase
  endfunction

  function automatic int max2(input int a, input int b);
    max2 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_text_writer_if.sv
// Signal bundle between the char source, the LCD pins and the writer.
//  index      : cell requested from the char source (0-15 line 1, 16-31 line 2)
//  char_in    : ASCII byte from the source, registered there (valid 1 cycle after index)
//  lcd_e/rs/rw/data : HD44780 8-bit bus, write only
//  frame_done : one-cycle pulse after cell 31 is written
//  init_done  : high once power-up init has completed
//  dbg_state / dbg_phase : sequencer state and write-phase, for observation only
// There is no valid/ready handshake here: the source is a pure registered
// lookup, so the writer simply waits one cycle after moving index before
// latching char_in.
interface lcd_text_writer_if;
  import lcd_pkg::*;

  logic [4:0] index;
  logic [7:0] char_in;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic       frame_done;
  logic       init_done;
  lcd_state_e dbg_state;
  wr_phase_e  dbg_phase;

  modport master (
    output index, lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done, init_done,
           dbg_state, dbg_phase,
    input  char_in
  );

  modport slave (
    input  index, lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done, init_done,
           dbg_state, dbg_phase,
    output char_in
  );
endinterface

// File: rtl/lcd_write_strobe.sv
// One LCD bus write followed by a timed wait, or a plain timed wait.
//  start    : begin an operation (only honoured in PH_IDLE)
//  delay    : with start, skip the bus write and just run the wait
//  rs_in/byte_in : captured at start, held on lcd_rs/lcd_data until the next write
//  wait_cyc : wait length, read when the wait phase is entered; caller keeps it stable
//  lcd_e/lcd_rs/lcd_data : registered LCD bus outputs
//  done     : one-cycle pulse when the wait has expired
//  phase    : current phase, for observation
// Write timing: SETUP (1 cycle, rs/data valid, E low), E high for E_CYC
// cycles, HOLD (1 cycle, E low, data held), then WAIT for wait_cyc cycles.
// The same counter times the E pulse and the wait.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int E_CYC = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             delay,
  input  logic             rs_in,
  input  logic [7:0]       byte_in,
  input  logic [CNT_W-1:0] wait_cyc,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic [7:0]       lcd_data,
  output logic             done,
  output wr_phase_e        phase
);

  wr_phase_e        phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             e_n, rs_n, done_n;
  logic [7:0]       data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      done     <= 1'b0;
    end else begin
      phase    <= phase_n;
      cnt      <= cnt_n;
      lcd_e    <= e_n;
      lcd_rs   <= rs_n;
      lcd_data <= data_n;
      done     <= done_n;
    end
  end

  always_comb begin
    phase_n = phase;
    cnt_n   = cnt;
    e_n     = 1'b0;
    rs_n    = lcd_rs;
    data_n  = lcd_data;
    done_n  = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (start) begin
          if (delay) begin
            phase_n = PH_WAIT;
            cnt_n   = wait_cyc - CNT_W'(1);
          end else begin
            phase_n = PH_SETUP;
            rs_n    = rs_in;
            data_n  = byte_in;
          end
        end
      end
      PH_SETUP: begin
        phase_n = PH_EHIGH;
        cnt_n   = CNT_W'(E_CYC - 1);
        e_n     = 1'b1;
      end
      PH_EHIGH: begin
        if (cnt == '0) begin
          phase_n = PH_HOLD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
          e_n   = 1'b1;
        end
      end
      PH_HOLD: begin
        phase_n = PH_WAIT;
        cnt_n   = wait_cyc - CNT_W'(1);
      end
      PH_WAIT: begin
        if (cnt == '0) begin
          phase_n = PH_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: phase_n = PH_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_text_writer.sv
// Writes a 32-cell character buffer to a 16x2 HD44780 LCD in 8-bit mode.
//  clk, rst : system clock, synchronous active-high reset
//  bus      : lcd_text_writer_if.master (index/char_in to the char source,
//             LCD pins, frame_done, init_done, debug state)
// Flow: power-up wait, four init commands, then forever: 0x80, cells 0-15,
// 0xC0, cells 16-31, frame_done pulse, refresh gap. All bus timing lives in
// lcd_write_strobe; this module only chooses what to send and for how long
// to wait afterwards.
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int PWR_CYC  = 750000,
  parameter int E_CYC    = 25,
  parameter int CMD_CYC  = 2500,
  parameter int CLR_CYC  = 100000,
  parameter int REFR_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  lcd_text_writer_if.master bus
);

  localparam int MAX_CYC = max2(max2(PWR_CYC, CLR_CYC), max2(REFR_CYC, max2(CMD_CYC, E_CYC)));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  lcd_state_e       state, state_n;
  logic [4:0]       index, index_n;
  logic [1:0]       init_step, step_n;
  logic             init_done, init_done_n;
  logic             frame_done, frame_done_n;

  logic             wr_start, wr_delay, wr_rs, wr_done;
  logic [7:0]       wr_byte;
  logic [CNT_W-1:0] wait_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PWR_GO;
      index      <= 5'd0;
      init_step  <= 2'd0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      index      <= index_n;
      init_step  <= step_n;
      init_done  <= init_done_n;
      frame_done <= frame_done_n;
    end
  end

  // Wait length depends only on the state, which is stable for the whole
  // operation, so the strobe can sample it whenever its wait begins.
  always_comb begin
    wait_cyc = CNT_W'(CMD_CYC);
    if (state == ST_PWR_GO || state == ST_PWR_WAIT)
      wait_cyc = CNT_W'(PWR_CYC);
    else if (state == ST_REFR_GO || state == ST_REFR_WAIT)
      wait_cyc = CNT_W'(REFR_CYC);
    else if ((state == ST_INIT_GO || state == ST_INIT_WAIT) &&
             init_step == 2'(INIT_LEN - 1))
      wait_cyc = CNT_W'(CLR_CYC);
  end

  always_comb begin
    state_n      = state;
    index_n      = index;
    step_n       = init_step;
    init_done_n  = init_done;
    frame_done_n = 1'b0;
    wr_start     = 1'b0;
    wr_delay     = 1'b0;
    wr_rs        = 1'b0;
    wr_byte      = 8'h00;
    case (state)
      ST_PWR_GO: begin
        wr_start = 1'b1;
        wr_delay = 1'b1;
        state_n  = ST_PWR_WAIT;
      end
      ST_PWR_WAIT: begin
        if (wr_done) begin
          step_n  = 2'd0;
          state_n = ST_INIT_GO;
        end
      end
      ST_INIT_GO: begin
        wr_start = 1'b1;
        wr_byte  = init_cmd(init_step);
        state_n  = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (wr_done) begin
          if (init_step == 2'(INIT_LEN - 1)) begin
            init_done_n = 1'b1;
            state_n     = ST_ADDR1_GO;
          end else begin
            step_n  = init_step + 2'd1;
            state_n = ST_INIT_GO;
          end
        end
      end
      ST_ADDR1_GO: begin
        wr_start = 1'b1;
        wr_byte  = LCD_L1;
        state_n  = ST_ADDR1_WAIT;
      end
      ST_ADDR1_WAIT: if (wr_done) state_n = ST_FETCH;
      // index has been on the bus since it last changed; this cycle lets
      // the source's registered output catch up before it is latched.
      ST_FETCH: state_n = ST_LATCH;
      ST_LATCH: begin
        wr_start = 1'b1;
        wr_rs    = 1'b1;
        wr_byte  = bus.char_in;
        state_n  = ST_CHAR_WAIT;
      end
      ST_CHAR_WAIT: begin
        if (wr_done) begin
          if (index == 5'd31) begin
            frame_done_n = 1'b1;
            state_n      = ST_REFR_GO;
          end else if (index == 5'd15) begin
            index_n = 5'd16;
            state_n = ST_ADDR2_GO;
          end else begin
            index_n = index + 5'd1;
            state_n = ST_FETCH;
          end
        end
      end
      ST_ADDR2_GO: begin
        wr_start = 1'b1;
        wr_byte  = LCD_L2;
        state_n  = ST_ADDR2_WAIT;
      end
      ST_ADDR2_WAIT: if (wr_done) state_n = ST_FETCH;
      ST_REFR_GO: begin
        wr_start = 1'b1;
        wr_delay = 1'b1;
        state_n  = ST_REFR_WAIT;
      end
      ST_REFR_WAIT: begin
        if (wr_done) begin
          index_n = 5'd0;
          state_n = ST_ADDR1_GO;
        end
      end
      default: state_n = ST_PWR_GO;
    endcase
  end

  lcd_write_strobe #(
    .CNT_W (CNT_W),
    .E_CYC (E_CYC)
  ) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .start    (wr_start),
    .delay    (wr_delay),
    .rs_in    (wr_rs),
    .byte_in  (wr_byte),
    .wait_cyc (wait_cyc),
    .lcd_e    (bus.lcd_e),
    .lcd_rs   (bus.lcd_rs),
    .lcd_data (bus.lcd_data),
    .done     (wr_done),
    .phase    (bus.dbg_phase)
  );

  assign bus.index      = index;
  assign bus.init_done  = init_done;
  assign bus.frame_done = frame_done;
  assign bus.lcd_rw     = 1'b0;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer with short timing parameters.
// A registered char ROM feeds the writer; every bus write is compared in
// order against an expected queue built from the display rules (init table,
// line address, 16 cells, line address, 16 cells). A monitor checks E pulse
// width, rs/data stability under E, rw, index sequencing and frame timing.
module tb_lcd_text_writer;
  import lcd_pkg::*;

  localparam int PWR  = 20;
  localparam int ECYC = 2;
  localparam int CMD  = 4;
  localparam int CLR  = 10;
  localparam int REFR = 30;

  logic clk;
  logic rst;
  lcd_text_writer_if bus ();

  lcd_text_writer #(
    .PWR_CYC  (PWR),
    .E_CYC    (ECYC),
    .CMD_CYC  (CMD),
    .CLR_CYC  (CLR),
    .REFR_CYC (REFR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic rst_q;
  always @(posedge clk) rst_q <= rst;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- char source model ----------------
  logic [7:0] rom [32];
  logic       scramble = 1'b0;

  // Registered lookup; while E is high the output is noise, which the
  // writer must ignore because it latched its byte before the write.
  always @(posedge clk) begin
    if (scramble && bus.lcd_e) bus.char_in <= 8'($urandom);
    else                       bus.char_in <= rom[bus.index];
  end

  task automatic load_text();
    logic [127:0] l1;
    logic [127:0] l2;
    l1 = "SET  2000/00/00 ";
    l2 = "TIME 00:00:00   ";
    for (int i = 0; i < 16; i++) begin
      rom[i]      = l1[127-8*i -: 8];
      rom[i + 16] = l2[127-8*i -: 8];
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom_range(32, 126));
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];

  task automatic push_init();
    for (int i = 0; i < INIT_LEN; i++) exp_q.push_back({1'b0, init_cmd(2'(i))});
  endtask

  task automatic push_frame();
    exp_q.push_back({1'b0, LCD_L1});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, rom[i]});
    exp_q.push_back({1'b0, LCD_L2});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, rom[i]});
  endtask

  // ---------------- bus monitor ----------------
  logic       prev_e, prev_fd, prev_init;
  logic [4:0] prev_idx;
  logic       e_rs;
  logic [7:0] e_data;
  logic [8:0] last_wr;
  logic       first_rise;
  int         e_len, since_rst, since_fall, since_fd, data_cnt, fd_len;

  always @(negedge clk) begin
    if (rst_q) begin
      prev_e     = bus.lcd_e;
      prev_fd    = 1'b0;
      prev_init  = bus.init_done;
      prev_idx   = bus.index;
      first_rise = 1'b1;
      e_len      = 0;
      since_rst  = 0;
      since_fall = 0;
      since_fd   = 0;
      data_cnt   = 0;
      fd_len     = 0;
      last_wr    = '0;
    end else begin
      since_rst++;
      since_fall++;
      since_fd++;
      if (bus.lcd_e && !prev_e) begin
        check_val("rw_zero", bus.lcd_rw, 0);
        if (first_rise) check_val("pwr_gap", since_rst >= PWR, 1);
        first_rise = 1'b0;
        e_len   = 1;
        e_rs    = bus.lcd_rs;
        e_data  = bus.lcd_data;
        last_wr = {bus.lcd_rs, bus.lcd_data};
        if (bus.lcd_rs) data_cnt++;
        if (exp_q.size() == 0) check_val("sb_unexpected", {23'd0, last_wr}, 32'hFFFF_FFFF);
        else check_val("sb_write", {23'd0, last_wr}, {23'd0, exp_q.pop_front()});
      end else if (bus.lcd_e && prev_e) begin
        e_len++;
        check_val("e_stable", {bus.lcd_rs, bus.lcd_data}, {e_rs, e_data});
      end else if (!bus.lcd_e && prev_e) begin
        check_val("e_width", e_len, ECYC);
        since_fall = 0;
      end
      if (bus.init_done && !prev_init) begin
        check_val("init_last_clr", {23'd0, last_wr}, {24'd0, LCD_CLR});
        check_val("clr_gap", since_fall >= CLR, 1);
      end
      if (bus.frame_done) begin
        fd_len++;
        if (!prev_fd) begin
          check_val("frame_cells", data_cnt, 32);
          check_val("frame_last_idx", bus.index, 31);
          data_cnt = 0;
          since_fd = 0;
        end
      end else if (prev_fd) begin
        check_val("fd_pulse", fd_len, 1);
        fd_len = 0;
      end
      if (bus.index != prev_idx) begin
        check_val("idx_e_low", bus.lcd_e, 0);
        if (prev_idx == 5'd31) begin
          check_val("idx_wrap", bus.index, 0);
          check_val("refr_gap", since_fd >= REFR, 1);
        end else begin
          check_val("idx_step", bus.index, prev_idx + 5'd1);
        end
      end
      prev_e    = bus.lcd_e;
      prev_fd   = bus.frame_done;
      prev_init = bus.init_done;
      prev_idx  = bus.index;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frame(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!bus.frame_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_val(tag, bus.frame_done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_e"},    bus.lcd_e, 0);
    check_val({tag, "_idx"},  bus.index, 0);
    check_val({tag, "_init"}, bus.init_done, 0);
    check_val({tag, "_rs"},   bus.lcd_rs, 0);
    check_val({tag, "_data"}, bus.lcd_data, 0);
    check_val({tag, "_fd"},   bus.frame_done, 0);
    check_val({tag, "_rw"},   bus.lcd_rw, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    rst = 1'b1;
    load_text();
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    push_init();
    push_frame();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Frame 1: fixed text. Frames 2 and 3: random text with noisy char_in.
    wait_frame("frame1_done");
    check_val("init_held_f1", bus.init_done, 1);
    load_random();
    scramble = 1'b1;
    push_frame();
    wait_frame("frame2_done");
    load_random();
    push_frame();

    // Reset in the middle of the E pulse for cell 7.
    cyc = 0;
    while (!(bus.index == 5'd7 && bus.lcd_e) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("found_cell7_e", bus.index == 5'd7 && bus.lcd_e, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_e",    bus.lcd_e, 0);
    check_val("midrst_idx",  bus.index, 0);
    check_val("midrst_init", bus.init_done, 0);
    rst = 1'b0;
    exp_q.delete();
    push_init();
    push_frame();
    wait_frame("frame_after_rst");
    check_val("init_held_rst", bus.init_done, 1);
    repeat (5) @(negedge clk);
    check_val("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
